// File: rtl/simon_data_in_pkg.sv
// Shared definitions for the SIMON byte-serial input deframer.
package simon_data_in_pkg;

  localparam logic [7:0] INFO_IDLE = 8'h00;

  typedef enum logic [1:0] {
    S_INFO,
    S_COUNT,
    S_DATA,
    S_HOLD
  } din_state_t;

endpackage

// File: rtl/simon_data_in.sv
// Byte-serial packet deframer: info, count, then 2N/8 data bytes assembled into a block
// held for the SIMON core until readIN; out-of-sequence packets are dropped with errCOUNT.
module simon_data_in
  import simon_data_in_pkg::*;
#(
  parameter int N = 16
) (
  input  logic                clk,
  input  logic                nR,
  input  logic [7:0]          byteIN,
  input  logic                byteVALID,
  output logic                byteREADY,
  output logic [7:0]          infoIN,
  output logic [7:0]          countIN,
  output logic [1:0][N-1:0]   inDATA,
  output logic                doneIN,
  input  logic                readIN,
  output logic                errCOUNT
);

  localparam int NB = (2 * N) / 8;
  localparam int BW = $clog2(NB + 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(NB - 1);

  din_state_t       state_q, state_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             match_q, match_d;
  logic [7:0]       info_q, info_d;
  logic [7:0]       count_q, count_d;
  logic [7:0]       exp_q, exp_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [2*N-1:0]   data_q, data_d;
  logic             xfer;

  // ready is registered, so a transfer never depends combinationally on readIN
  assign xfer = byteVALID & ready_q;

  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      state_q <= S_INFO;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      match_q <= 1'b0;
      info_q  <= '0;
      count_q <= '0;
      exp_q   <= '0;
      bcnt_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      match_q <= match_d;
      info_q  <= info_d;
      count_q <= count_d;
      exp_q   <= exp_d;
      bcnt_q  <= bcnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    match_d = match_q;
    info_d  = info_q;
    count_d = count_q;
    exp_d   = exp_q;
    bcnt_d  = bcnt_q;
    data_d  = data_q;

    unique case (state_q)
      S_INFO: begin
        if (xfer && byteIN != INFO_IDLE) begin
          info_d  = byteIN;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (xfer) begin
          count_d = byteIN;
          match_d = (byteIN == exp_q);
          bcnt_d  = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          data_d = {data_q[2*N-9:0], byteIN};
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BCNT_LAST) begin
            if (match_q) begin
              exp_d   = exp_q + 8'd1;
              state_d = S_HOLD;
            end else begin
              err_d   = 1'b1;
              state_d = S_INFO;
            end
          end
        end
      end
      S_HOLD: begin
        if (readIN) state_d = S_INFO;
      end
      default: state_d = S_INFO;
    endcase

    done_d  = (state_d == S_HOLD);
    ready_d = (state_d != S_HOLD);
  end

  assign byteREADY = ready_q;
  assign doneIN    = done_q;
  assign errCOUNT  = err_q;
  assign infoIN    = info_q;
  assign countIN   = count_q;
  assign inDATA    = data_q;

endmodule

// File: tb/tb_simon_data_in.sv
// Directed bench for simon_data_in (N=16, four data bytes per packet).
module tb_simon_data_in;

  logic              clk = 1'b0;
  logic              nR = 1'b0;
  logic [7:0]        byteIN = 8'h00;
  logic              byteVALID = 1'b0;
  logic              byteREADY;
  logic [7:0]        infoIN;
  logic [7:0]        countIN;
  logic [1:0][15:0]  inDATA;
  logic              doneIN;
  logic              readIN = 1'b0;
  logic              errCOUNT;

  int n_checks = 0;
  int n_fail   = 0;

  simon_data_in #(.N(16)) dut (
    .clk(clk), .nR(nR), .byteIN(byteIN), .byteVALID(byteVALID), .byteREADY(byteREADY),
    .infoIN(infoIN), .countIN(countIN), .inDATA(inDATA), .doneIN(doneIN),
    .readIN(readIN), .errCOUNT(errCOUNT)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byteIN    = b;
    byteVALID = 1'b1;
    for (int k = 0; k < 20; k++) if (!byteREADY) @(negedge clk);
    chk("ready_wait", {31'd0, byteREADY}, 32'd1);
    @(posedge clk);
    #1;
    byteVALID = 1'b0;
    byteIN    = 8'h00;
  endtask

  task automatic pulse_read();
    @(negedge clk);
    readIN = 1'b1;
    @(posedge clk);
    #1;
    readIN = 1'b0;
  endtask

  task automatic chk_block(input string tag, input logic [7:0] inf, input logic [7:0] cnt,
                           input logic [15:0] w1, input logic [15:0] w0);
    chk({tag, "_done"},  {31'd0, doneIN},    32'd1);
    chk({tag, "_ready"}, {31'd0, byteREADY}, 32'd0);
    chk({tag, "_info"},  {24'd0, infoIN},    {24'd0, inf});
    chk({tag, "_count"}, {24'd0, countIN},   {24'd0, cnt});
    chk({tag, "_w1"},    {16'd0, inDATA[1]}, {16'd0, w1});
    chk({tag, "_w0"},    {16'd0, inDATA[0]}, {16'd0, w0});
  endtask

  initial begin
    // 1: reset
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, byteREADY}, 32'd0);
    chk("rst_done",  {31'd0, doneIN},    32'd0);
    chk("rst_err",   {31'd0, errCOUNT},  32'd0);
    chk("rst_info",  {24'd0, infoIN},    32'd0);
    chk("rst_count", {24'd0, countIN},   32'd0);
    chk("rst_data",  inDATA,             32'd0);
    nR = 1'b1;
    #1 chk("rel_ready_pre", {31'd0, byteREADY}, 32'd0);
    @(posedge clk); #1;
    chk("rel_ready_post", {31'd0, byteREADY}, 32'd1);

    // 2: basic packet, EXP=0
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    send_byte(8'hBB); send_byte(8'hCC);
    chk("p1_done_early", {31'd0, doneIN}, 32'd0);
    send_byte(8'hDD);
    chk_block("p1", 8'h01, 8'h00, 16'hAABB, 16'hCCDD);
    @(posedge clk); #1;
    chk("p1_hold_done", {31'd0, doneIN}, 32'd1);
    pulse_read();
    chk("p1_read_done",  {31'd0, doneIN},    32'd0);
    chk("p1_read_ready", {31'd0, byteREADY}, 32'd1);

    // 3: fillers and gaps, EXP=1
    send_byte(8'h00); send_byte(8'h00);
    chk("p2_filler_info", {24'd0, infoIN}, 32'h01);
    send_byte(8'h02);
    repeat (2) @(negedge clk);
    send_byte(8'h01); send_byte(8'h11);
    repeat (3) @(negedge clk);
    send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    send_byte(8'h44);
    chk_block("p2", 8'h02, 8'h01, 16'h1122, 16'h3344);
    pulse_read();
    chk("p2_read_done", {31'd0, doneIN}, 32'd0);

    // 4: out-of-order count 05 while EXP=2, then in-order resend
    send_byte(8'h03); send_byte(8'h05); send_byte(8'hDE);
    send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    chk("p3_err_pulse", {31'd0, errCOUNT},  32'd1);
    chk("p3_err_done",  {31'd0, doneIN},    32'd0);
    chk("p3_err_ready", {31'd0, byteREADY}, 32'd1);
    @(posedge clk); #1;
    chk("p3_err_clear", {31'd0, errCOUNT}, 32'd0);
    chk("p3_err_done2", {31'd0, doneIN},   32'd0);
    send_byte(8'h03); send_byte(8'h02); send_byte(8'h12);
    send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    chk("p4_err", {31'd0, errCOUNT}, 32'd0);
    chk_block("p4", 8'h03, 8'h02, 16'h1234, 16'h5678);

    // 5: bytes offered during hold are not consumed
    @(negedge clk);
    byteIN = 8'h04; byteVALID = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_block("p5_hold", 8'h03, 8'h02, 16'h1234, 16'h5678);
    @(negedge clk);
    readIN = 1'b1;
    @(posedge clk); #1;
    readIN = 1'b0;
    chk("p5_read_done",  {31'd0, doneIN},    32'd0);
    chk("p5_read_ready", {31'd0, byteREADY}, 32'd1);
    chk("p5_info_kept",  {24'd0, infoIN},    32'h03);
    @(posedge clk); #1;
    byteVALID = 1'b0;
    chk("p5_info_taken", {24'd0, infoIN}, 32'h04);
    send_byte(8'h03); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04);
    chk_block("p5", 8'h04, 8'h03, 16'h0102, 16'h0304);
    pulse_read();

    // 6: reset mid-packet; EXP returns to 0
    send_byte(8'h05); send_byte(8'h04); send_byte(8'hA1);
    send_byte(8'hB2); send_byte(8'hC3);
    @(negedge clk);
    nR = 1'b0;
    #1;
    chk("p6_rst_ready", {31'd0, byteREADY}, 32'd0);
    chk("p6_rst_info",  {24'd0, infoIN},    32'd0);
    chk("p6_rst_count", {24'd0, countIN},   32'd0);
    chk("p6_rst_data",  inDATA,             32'd0);
    chk("p6_rst_done",  {31'd0, doneIN},    32'd0);
    @(negedge clk);
    nR = 1'b1;
    send_byte(8'h06); send_byte(8'h00); send_byte(8'h0F);
    send_byte(8'h1E); send_byte(8'h2D); send_byte(8'h3C);
    chk("p6_err", {31'd0, errCOUNT}, 32'd0);
    chk_block("p6", 8'h06, 8'h00, 16'h0F1E, 16'h2D3C);
    pulse_read();
    chk("p6_read_done", {31'd0, doneIN}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
